// File: rtl/ex_unit_if.sv
// ---------------------------------------------------------------------------
// ex_unit_if
// Groups the ID/EX-side inputs and EX/MEM-side outputs of the execute stage.
//   master : the pipeline (drives operands and control, observes results)
//   slave  : ex_unit (consumes operands and control, drives results)
// Signals:
//   alusel_i[2:0]     op class        aluop_i[4:0]      op within class
//   op1_i, op2_i      operands        link_addr_i       return address
//   write_i           rf write enable regw_addr_i[4:0]  rf destination
//   mem_offset_i      ld/st offset    wdata_o           result
//   write_o, regw_addr_o, aluop_o     forwarded control
//   mem_addr_o, mem_data_o            ld/st address and store data
//   stall_req_o       hold IF/ID/EX while the divider is running
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface ex_unit_if;
  logic [2:0]  alusel_i;
  logic [4:0]  aluop_i;
  logic [31:0] op1_i;
  logic [31:0] op2_i;
  logic [31:0] link_addr_i;
  logic        write_i;
  logic [4:0]  regw_addr_i;
  logic [31:0] mem_offset_i;
  logic [31:0] wdata_o;
  logic        write_o;
  logic [4:0]  regw_addr_o;
  logic [4:0]  aluop_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        stall_req_o;

  modport master (
    output alusel_i, aluop_i, op1_i, op2_i, link_addr_i,
           write_i, regw_addr_i, mem_offset_i,
    input  wdata_o, write_o, regw_addr_o, aluop_o,
           mem_addr_o, mem_data_o, stall_req_o
  );

  modport slave (
    input  alusel_i, aluop_i, op1_i, op2_i, link_addr_i,
           write_i, regw_addr_i, mem_offset_i,
    output wdata_o, write_o, regw_addr_o, aluop_o,
           mem_addr_o, mem_data_o, stall_req_o
  );
endinterface

`default_nettype wire

// File: rtl/ex_unit.sv
// ---------------------------------------------------------------------------
// ex_unit
// Execute stage: logic, shift, arithmetic, jump-link, load/store address
// generation and a 32-step restoring divider (DIV/DIVU/REM/REMU).
// Ports:
//   clock  in  rising-edge clock
//   reset  in  synchronous, active-high reset
//   bus    ex_unit_if.slave  operands/control in, results/stall out
// Everything except the divider is purely combinational.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module ex_unit (
  input  wire logic clock,
  input  wire logic reset,
  ex_unit_if.slave  bus
);

  localparam logic [2:0] SEL_NOP   = 3'd0;
  localparam logic [2:0] SEL_LOGIC = 3'd1;
  localparam logic [2:0] SEL_SHIFT = 3'd2;
  localparam logic [2:0] SEL_ARITH = 3'd3;
  localparam logic [2:0] SEL_JUMP  = 3'd4;
  localparam logic [2:0] SEL_LDST  = 3'd5;
  localparam logic [2:0] SEL_DIV   = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  div_state_t  state;
  logic [4:0]  count;
  logic [31:0] quot;      // dividend bits shift out the top, quotient bits in
  logic [31:0] partial;   // running remainder
  logic [31:0] divisor;
  logic        neg_q;
  logic        neg_r;
  logic        want_rem;
  logic [31:0] result;

  // Entry decode of the divide request
  logic        is_div;
  logic        div_signed;
  logic        div_rem;
  logic        op1_neg;
  logic        op2_neg;
  logic [31:0] mag1;
  logic [31:0] mag2;
  logic        div_zero;
  logic        div_ovf;
  logic [31:0] special;

  assign is_div     = (bus.alusel_i == SEL_DIV);
  assign div_signed = ~bus.aluop_i[0];
  assign div_rem    = bus.aluop_i[1];
  assign op1_neg    = div_signed & bus.op1_i[31];
  assign op2_neg    = div_signed & bus.op2_i[31];
  assign mag1       = op1_neg ? (32'd0 - bus.op1_i) : bus.op1_i;
  assign mag2       = op2_neg ? (32'd0 - bus.op2_i) : bus.op2_i;
  assign div_zero   = (bus.op2_i == 32'd0);
  assign div_ovf    = div_signed & (bus.op1_i == 32'h8000_0000)
                                 & (bus.op2_i == 32'hFFFF_FFFF);

  // Divide-by-zero wins over overflow (they cannot both hold anyway)
  always_comb begin
    special = 32'd0;
    if (div_zero)
      special = div_rem ? bus.op1_i : 32'hFFFF_FFFF;
    else
      special = div_rem ? 32'd0 : 32'h8000_0000;
  end

  // One restoring step: shift next dividend bit into the remainder and
  // subtract the divisor; bit 32 of the trial is the borrow.
  logic [32:0] shifted;
  logic [32:0] trial;
  logic        fits;
  logic [31:0] next_partial;
  logic [31:0] next_quot;
  logic [31:0] final_val;

  assign shifted      = {partial, quot[31]};
  assign trial        = shifted - {1'b0, divisor};
  assign fits         = ~trial[32];
  assign next_partial = fits ? trial[31:0] : shifted[31:0];
  assign next_quot    = {quot[30:0], fits};

  always_comb begin
    final_val = 32'd0;
    if (want_rem)
      final_val = neg_r ? (32'd0 - next_partial) : next_partial;
    else
      final_val = neg_q ? (32'd0 - next_quot) : next_quot;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      count    <= 5'd0;
      quot     <= 32'd0;
      partial  <= 32'd0;
      divisor  <= 32'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      want_rem <= 1'b0;
      result   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (is_div) begin
            if (div_zero || div_ovf) begin
              result <= special;
              state  <= DONE;
            end else begin
              quot     <= mag1;
              partial  <= 32'd0;
              divisor  <= mag2;
              neg_q    <= op1_neg ^ op2_neg;
              neg_r    <= op1_neg;
              want_rem <= div_rem;
              count    <= 5'd0;
              state    <= BUSY;
            end
          end
        end
        BUSY: begin
          if (!is_div) begin
            state <= IDLE;      // flushed by the pipeline
          end else begin
            quot    <= next_quot;
            partial <= next_partial;
            count   <= count + 5'd1;
            if (count == 5'd31) begin
              result <= final_val;
              state  <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath
  logic [4:0]  shamt;
  logic [31:0] wdata;
  logic        write_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;

  assign shamt = bus.op2_i[4:0];

  always_comb begin
    wdata    = 32'd0;
    write_en = bus.write_i;
    mem_addr = 32'd0;
    mem_data = 32'd0;
    case (bus.alusel_i)
      SEL_LOGIC: begin
        case (bus.aluop_i)
          5'd0:    wdata = bus.op1_i & bus.op2_i;
          5'd1:    wdata = bus.op1_i | bus.op2_i;
          5'd2:    wdata = bus.op1_i ^ bus.op2_i;
          default: wdata = 32'd0;
        endcase
      end
      SEL_SHIFT: begin
        case (bus.aluop_i)
          5'd0:    wdata = bus.op1_i << shamt;
          5'd1:    wdata = bus.op1_i >> shamt;
          5'd2:    wdata = $unsigned($signed(bus.op1_i) >>> shamt);
          default: wdata = 32'd0;
        endcase
      end
      SEL_ARITH: begin
        case (bus.aluop_i)
          5'd0:    wdata = bus.op1_i + bus.op2_i;
          5'd1:    wdata = bus.op1_i - bus.op2_i;
          5'd2:    wdata = {31'd0, $signed(bus.op1_i) < $signed(bus.op2_i)};
          5'd3:    wdata = {31'd0, bus.op1_i < bus.op2_i};
          default: wdata = 32'd0;
        endcase
      end
      SEL_JUMP: wdata = bus.link_addr_i;
      SEL_LDST: begin
        mem_addr = bus.op1_i + bus.mem_offset_i;
        mem_data = bus.op2_i;
      end
      SEL_DIV:  wdata = (state == DONE) ? result : 32'd0;
      default:  write_en = 1'b0;   // NOP and undefined classes
    endcase
  end

  // Stall is combinational so the request is visible in the entry cycle.
  assign bus.stall_req_o = ~reset & is_div & ((state == IDLE) | (state == BUSY));
  assign bus.wdata_o     = reset ? 32'd0 : wdata;
  assign bus.write_o     = ~reset & write_en;
  assign bus.regw_addr_o = reset ? 5'd0  : bus.regw_addr_i;
  assign bus.aluop_o     = reset ? 5'd0  : bus.aluop_i;
  assign bus.mem_addr_o  = reset ? 32'd0 : mem_addr;
  assign bus.mem_data_o  = reset ? 32'd0 : mem_data;

endmodule

`default_nettype wire

// File: tb/tb_ex_unit.sv
// ---------------------------------------------------------------------------
// tb_ex_unit
// Directed self-checking bench for ex_unit: reset values, each ALU class,
// load/store address generation, divider latency/results, divider special
// cases, reset abort and pipeline flush.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ex_unit;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  ex_unit_if bus ();

  ex_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply a vector just after a rising edge, return at the falling edge.
  task automatic drive(input logic [2:0] sel, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    @(posedge clock); #1;
    bus.alusel_i = sel;
    bus.aluop_i  = op;
    bus.op1_i    = a;
    bus.op2_i    = b;
    @(negedge clock);
  endtask

  // Issue a divide, hold it while stalled, check stall length and result.
  task automatic run_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int exp_stall, input logic [31:0] exp_w, input string tag);
    int n;
    n = 0;
    drive(3'd6, op, a, b);
    while (bus.stall_req_o && n < 80) begin
      n++;
      @(negedge clock);
    end
    check({tag, "_stall"}, n, exp_stall);
    check({tag, "_wdata"}, bus.wdata_o, exp_w);
    drive(3'd0, 5'd0, 32'd0, 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.alusel_i     = 3'd5;
    bus.aluop_i      = 5'd3;
    bus.op1_i        = 32'h0000_1000;
    bus.op2_i        = 32'h1234_5678;
    bus.link_addr_i  = 32'h0000_1234;
    bus.write_i      = 1'b1;
    bus.regw_addr_i  = 5'd9;
    bus.mem_offset_i = 32'hFFFF_FFFC;

    // Outputs forced to zero while reset is high
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_stall",   {31'd0, bus.stall_req_o}, 32'd0);
    check("rst_write",   {31'd0, bus.write_o},     32'd0);
    check("rst_wdata",   bus.wdata_o,              32'd0);
    check("rst_maddr",   bus.mem_addr_o,           32'd0);
    check("rst_mdata",   bus.mem_data_o,           32'd0);
    check("rst_regw",    {27'd0, bus.regw_addr_o}, 32'd0);
    check("rst_aluop",   {27'd0, bus.aluop_o},     32'd0);
    bus.alusel_i = 3'd6;
    #1;
    check("rst_div_stall", {31'd0, bus.stall_req_o}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    bus.alusel_i = 3'd0;

    // LOGIC
    drive(3'd1, 5'd0, 32'hF0F0_FF00, 32'h0FF0_0FF0); check("and", bus.wdata_o, 32'h00F0_0F00);
    drive(3'd1, 5'd1, 32'hF0F0_FF00, 32'h0FF0_0FF0); check("or",  bus.wdata_o, 32'hFFF0_FFF0);
    drive(3'd1, 5'd2, 32'hF0F0_FF00, 32'h0FF0_0FF0); check("xor", bus.wdata_o, 32'hFF00_F0F0);
    drive(3'd1, 5'd5, 32'hF0F0_FF00, 32'h0FF0_0FF0); check("logic_undef", bus.wdata_o, 32'd0);
    check("fwd_aluop", {27'd0, bus.aluop_o},     32'd5);
    check("fwd_regw",  {27'd0, bus.regw_addr_o}, 32'd9);
    // SHIFT (only op2[4:0] counts)
    drive(3'd2, 5'd0, 32'h0000_0001, 32'h0000_0021); check("sll", bus.wdata_o, 32'h0000_0002);
    drive(3'd2, 5'd1, 32'h8000_0000, 32'h0000_0004); check("srl", bus.wdata_o, 32'h0800_0000);
    drive(3'd2, 5'd2, 32'h8000_0000, 32'h0000_0024); check("sra", bus.wdata_o, 32'hF800_0000);
    // ARITH
    drive(3'd3, 5'd0, 32'hFFFF_FFFF, 32'h0000_0002); check("add",  bus.wdata_o, 32'h0000_0001);
    drive(3'd3, 5'd1, 32'd5, 32'd7);                 check("sub",  bus.wdata_o, 32'hFFFF_FFFE);
    drive(3'd3, 5'd2, 32'd5, 32'd7);                 check("slt",  bus.wdata_o, 32'd1);
    drive(3'd3, 5'd2, 32'hFFFF_FFFF, 32'd1);         check("slt_neg", bus.wdata_o, 32'd1);
    drive(3'd3, 5'd3, 32'hFFFF_FFFF, 32'd1);         check("sltu", bus.wdata_o, 32'd0);
    check("arith_stall", {31'd0, bus.stall_req_o}, 32'd0);
    check("arith_maddr", bus.mem_addr_o, 32'd0);
    // JUMP / LDST / NOP / undefined
    drive(3'd4, 5'd0, 32'd1, 32'd2);
    check("jump_wdata", bus.wdata_o, 32'h0000_1234);
    check("jump_write", {31'd0, bus.write_o}, 32'd1);
    drive(3'd5, 5'd0, 32'h0000_1000, 32'hCAFE_BABE);
    check("ldst_maddr", bus.mem_addr_o, 32'h0000_0FFC);
    check("ldst_mdata", bus.mem_data_o, 32'hCAFE_BABE);
    check("ldst_wdata", bus.wdata_o, 32'd0);
    drive(3'd0, 5'd0, 32'd3, 32'd4);
    check("nop_write", {31'd0, bus.write_o}, 32'd0);
    check("nop_wdata", bus.wdata_o, 32'd0);
    drive(3'd7, 5'd0, 32'd3, 32'd4);
    check("undef_write", {31'd0, bus.write_o}, 32'd0);

    // Divider
    run_div(5'd0, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, "div_m7_2");
    run_div(5'd2, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, "rem_m7_2");
    run_div(5'd0, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, "div_7_m2");
    run_div(5'd2, 32'd7, 32'hFFFF_FFFE, 33, 32'd1,         "rem_7_m2");
    run_div(5'd1, 32'd100, 32'd7,       33, 32'd14,        "divu_100_7");
    run_div(5'd3, 32'd100, 32'd7,       33, 32'd2,         "remu_100_7");
    run_div(5'd1, 32'hFFFF_FFFF, 32'd1, 33, 32'hFFFF_FFFF, "divu_max_1");
    run_div(5'd1, 32'd5, 32'd0,         1,  32'hFFFF_FFFF, "divu_by0");
    run_div(5'd3, 32'd5, 32'd0,         1,  32'd5,         "remu_by0");
    run_div(5'd0, 32'hFFFF_FFF9, 32'd0, 1,  32'hFFFF_FFFF, "div_by0");
    run_div(5'd2, 32'hFFFF_FFF9, 32'd0, 1,  32'hFFFF_FFF9, "rem_by0");
    run_div(5'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, "div_ovf");
    run_div(5'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0,         "rem_ovf");

    // Reset in the 10th BUSY cycle aborts the division
    drive(3'd6, 5'd1, 32'd1000, 32'd3);
    check("abort_entry_stall", {31'd0, bus.stall_req_o}, 32'd1);
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    check("abort_rst_stall", {31'd0, bus.stall_req_o}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    bus.alusel_i = 3'd0;
    @(negedge clock);
    check("abort_after_stall", {31'd0, bus.stall_req_o}, 32'd0);
    check("abort_after_wdata", bus.wdata_o, 32'd0);
    run_div(5'd1, 32'd100, 32'd7, 33, 32'd14, "post_abort_divu");

    // Flush in the 5th BUSY cycle
    drive(3'd6, 5'd0, 32'hFFFF_FFF9, 32'd2);
    check("flush_entry_stall", {31'd0, bus.stall_req_o}, 32'd1);
    repeat (5) @(posedge clock);
    #1;
    bus.alusel_i = 3'd0;
    @(negedge clock);
    check("flush_stall", {31'd0, bus.stall_req_o}, 32'd0);
    check("flush_wdata", bus.wdata_o, 32'd0);
    bus.mem_offset_i = 32'hFFFF_FFFC;
    drive(3'd5, 5'd0, 32'h0000_1000, 32'd0);
    check("flush_ldst_maddr", bus.mem_addr_o, 32'h0000_0FFC);
    run_div(5'd0, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, "post_flush_div");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ex_unit.md
EX_UNIT -- requirements
Module: ex_unit

Interface
REQ-001 clock  in  1  rising-edge clock.
REQ-002 reset  in  1  reset, synchronous, active-high.
REQ-003 alusel_i  in  3  op class: 0 NOP, 1 LOGIC, 2 SHIFT, 3 ARITH, 4 JUMP, 5 LDST, 6 DIV.
REQ-004 aluop_i  in  5  op within class; passed to MEM stage.
REQ-005 op1_i, op2_i  in  32 each  operands from ID/EX register.
REQ-006 link_addr_i  in  32  return address for JUMP.
REQ-007 write_i  in  1  regfile write enable; regw_addr_i  in  5  destination.
REQ-008 mem_offset_i  in  32  load/store immediate.
REQ-009 wdata_o  out  32  result to EX/MEM register.
REQ-010 write_o  out  1; regw_addr_o  out  5  copies of write_i/regw_addr_i.
REQ-011 aluop_o  out  5  copy of aluop_i; mem_addr_o  out  32; mem_data_o  out  32.
REQ-012 stall_req_o  out  1  high = hold IF/ID/EX, insert bubble after EX.

Function
REQ-013 Datapath outputs SHALL be combinational in current inputs and divider state; only divider state is registered.
REQ-014 LOGIC: aluop 0 AND, 1 OR, 2 XOR; other aluop -> wdata 0.
REQ-015 SHIFT: aluop 0 SLL, 1 SRL, 2 SRA; amount op2_i[4:0] only.
REQ-016 ARITH: aluop 0 ADD, 1 SUB (mod 2^32), 2 SLT signed, 3 SLTU; compare result zero-extended 0/1.
REQ-017 JUMP: wdata_o = link_addr_i.
REQ-018 LDST: mem_addr_o = op1_i + mem_offset_i mod 2^32; mem_data_o = op2_i; wdata_o = 0; in all other classes mem_addr_o = mem_data_o = 0.
REQ-019 NOP or undefined alusel: wdata_o = 0, write_o = 0.
REQ-020 DIV: aluop 0 DIV, 1 DIVU, 2 REM, 3 REMU; RISC-V M semantics; remainder sign = dividend sign.
REQ-021 Divider FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-022 IDLE with alusel_i=DIV: stall_req_o=1 same cycle; latch |op1|,|op2| (signed ops) or raw values, result signs, op; counter=0; next BUSY.
REQ-023 IDLE with DIV and op2_i=0 or signed (op1=0x80000000, op2=0xFFFFFFFF): no iteration; latch special result; next DONE.
REQ-024 BUSY: one restoring shift-subtract step per cycle, stall_req_o=1; after 32nd step (counter 31) next DONE.
REQ-025 DONE: stall_req_o=0, wdata_o = latched sign-corrected quotient/remainder; next IDLE unconditionally.
REQ-026 Normal DIV stall = 33 cycles (IDLE entry + 32 BUSY), result in 34th; special case stall 1 cycle, result in 2nd.
REQ-027 Divide by zero: quotient 0xFFFFFFFF, remainder = op1_i; overflow: quotient 0x80000000, remainder 0.
REQ-028 BUSY or DONE with alusel_i != DIV (flush): return to IDLE next cycle, stall_req_o=0, outputs per current inputs.
REQ-029 stall_req_o SHALL be 0 whenever alusel_i != DIV.
REQ-030 Upstream SHALL hold all inputs stable while stall_req_o=1; ex_unit does not re-sample operands after entry.

Reset
REQ-031 reset high at clock edge: FSM -> IDLE, counter/registers cleared.
REQ-032 While reset high: stall_req_o, write_o, wdata_o, mem_addr_o, mem_data_o, regw_addr_o, aluop_o = 0.
REQ-033 Reset mid-division SHALL abort it; no stale result after release.

Verification
REQ-034 ARITH SUB op1=5, op2=7 -> wdata 0xFFFFFFFE; SLT same operands -> 1; SLTU 0xFFFFFFFF vs 1 -> 0.
REQ-035 SHIFT SRA op1=0x80000000, op2=0x24 -> wdata 0xF8000000 (amount 4).
REQ-036 DIV op1=-7, op2=2 held -> stall_req 1 for 33 cycles, then wdata 0xFFFFFFFD one cycle; REM -> 0xFFFFFFFF.
REQ-037 DIVU op2=0 -> stall 1 cycle, wdata 0xFFFFFFFF; REMU -> op1; DIV 0x80000000/-1 -> 0x80000000.
REQ-038 Reset at BUSY cycle 10 -> stall_req 0 next cycle; next DIVU 100/7 gives 14 after full latency.
REQ-039 Flush at BUSY cycle 5 (alusel -> NOP) -> IDLE, stall_req 0, wdata 0; LDST op1=0x1000, offset=-4 -> mem_addr 0xFFC.
